pin_key_encoder: RTL

PIN-entry front end that produces the 2-bit `KEY` arm/disarm command consumed by the security alarm FSM. An operator sets a digit on `DIGIT` and presses `BTN_ENTER`, four times. When the 4-digit code matches `PIN`, the block drives `KEY` to arm (2'b11) or disarm (2'b00) for a fixed number of cycles; at all other times it drives the neutral code 2'b01. The block debounces its buttons, clears stale partial entries on timeout, and locks out after repeated failures.

---
 rtl/pin_key_encoder.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pin_key_encoder.sv
// pin_key_encoder: PIN-entry front end for the alarm FSM.
// Debounces ENTER/CLEAR, collects four digits, compares them against PIN
// and emits a timed arm/disarm command on KEY. Repeated failures lock the
// keypad for a fixed period; stale partial entries are dropped on timeout.
module pin_key_encoder #(
    parameter int unsigned CLK_FREQ        = 125_000_000,
    parameter logic [15:0] PIN             = 16'h1234,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned ENTRY_TIMEOUT_S = 10,
    parameter int unsigned MAX_FAIL        = 3,
    parameter int unsigned LOCKOUT_S       = 30,
    parameter int unsigned CMD_HOLD        = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] DIGIT,
    input  logic       ARM_REQ,
    input  logic       BTN_ENTER,
    input  logic       BTN_CLEAR,
    output logic [1:0] KEY,
    output logic [2:0] DIGIT_CNT,
    output logic       LOCKED,
    output logic       ERR
);

    // Cycle counts derived from the clock frequency; all fit in 32 bits
    // unsigned for the supported parameter range.
    localparam int unsigned DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned TO_CYC   = ENTRY_TIMEOUT_S * CLK_FREQ;
    localparam int unsigned LOCK_CYC = LOCKOUT_S * CLK_FREQ;

    // Terminal values for the counters (count from 0 to N-1).
    localparam logic [31:0] DB_LAST   = (DB_CYC   > 0) ? 32'(DB_CYC - 1)   : 32'd0;
    localparam logic [31:0] TO_LAST   = (TO_CYC   > 0) ? 32'(TO_CYC - 1)   : 32'd0;
    localparam logic [31:0] LOCK_LAST = (LOCK_CYC > 0) ? 32'(LOCK_CYC - 1) : 32'd0;
    localparam logic [31:0] CMD_LAST  = (CMD_HOLD > 0) ? 32'(CMD_HOLD - 1) : 32'd0;
    localparam logic [1:0]  FAIL_MAX  = 2'(MAX_FAIL);

    localparam logic [1:0] KEY_NEUTRAL = 2'b01;

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = ENTER, index 1 = CLEAR.
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] btn_press;

    assign btn_raw = {BTN_CLEAR, BTN_ENTER};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]  sync_q, sync_d;
            logic        level_q, level_d;
            logic        press_q, press_d;
            logic [31:0] db_cnt_q, db_cnt_d;

            // Synchronize, then only flip the debounced level after the
            // input has disagreed with it for DB_CYC consecutive cycles.
            always_comb begin
                sync_d   = {sync_q[0], btn_raw[gi]};
                level_d  = level_q;
                db_cnt_d = 32'd0;
                if (sync_q[1] != level_q) begin
                    if (db_cnt_q >= DB_LAST) begin
                        level_d = sync_q[1];
                    end else begin
                        db_cnt_d = db_cnt_q + 32'd1;
                    end
                end
                // Strobe coincides with the first cycle of the high level.
                press_d = level_d & ~level_q;
            end

            // Debouncer state registers.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync_q   <= 2'b00;
                    level_q  <= 1'b0;
                    press_q  <= 1'b0;
                    db_cnt_q <= 32'd0;
                end else begin
                    sync_q   <= sync_d;
                    level_q  <= level_d;
                    press_q  <= press_d;
                    db_cnt_q <= db_cnt_d;
                end
            end

            assign btn_press[gi] = press_q;
        end
    endgenerate

    logic enter_stb;
    logic clear_stb;

    assign enter_stb = btn_press[0];
    assign clear_stb = btn_press[1];

    // ------------------------------------------------------------------
    // Entry / command FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_CMD,
        S_LOCKOUT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] code_q, code_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        arm_q, arm_d;
    logic [1:0]  fail_q, fail_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  key_q, key_d;
    logic        err_q, err_d;
    logic        locked_q, locked_d;
    logic [1:0]  fail_inc;
    logic [15:0] code_shift;

    // Next-state and registered-output logic. One shared timer serves the
    // entry timeout, the command hold and the lockout period, since only
    // one of them is ever running.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        arm_d      = arm_q;
        fail_d     = fail_q;
        timer_d    = timer_q;
        err_d      = 1'b0;
        fail_inc   = (fail_q >= FAIL_MAX) ? fail_q : fail_q + 2'd1;
        // Digits shift in at the bottom, so the first one ends up in [15:12].
        code_shift = {code_q[11:0], DIGIT};

        case (state_q)
            S_IDLE: begin
                cnt_d   = 3'd0;
                timer_d = 32'd0;
                if (enter_stb && !clear_stb) begin
                    code_d  = code_shift;
                    cnt_d   = 3'd1;
                    state_d = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (clear_stb) begin
                    cnt_d   = 3'd0;
                    timer_d = 32'd0;
                    state_d = S_IDLE;
                end else if (enter_stb) begin
                    code_d  = code_shift;
                    cnt_d   = cnt_q + 3'd1;
                    timer_d = 32'd0;
                    if (cnt_q == 3'd3) begin
                        arm_d   = ARM_REQ;
                        err_d   = (code_shift != PIN);
                        state_d = S_CHECK;
                    end
                end else if (timer_q >= TO_LAST) begin
                    cnt_d   = 3'd0;
                    timer_d = 32'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            S_CHECK: begin
                cnt_d   = 3'd0;
                timer_d = 32'd0;
                if (code_q == PIN) begin
                    fail_d  = 2'd0;
                    state_d = S_CMD;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc >= FAIL_MAX) ? S_LOCKOUT : S_IDLE;
                end
            end

            S_CMD: begin
                if (timer_q >= CMD_LAST) begin
                    timer_d = 32'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            S_LOCKOUT: begin
                if (timer_q >= LOCK_LAST) begin
                    timer_d = 32'd0;
                    fail_d  = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            default: begin
                cnt_d   = 3'd0;
                timer_d = 32'd0;
                state_d = S_IDLE;
            end
        endcase

        key_d    = (state_d == S_CMD) ? {arm_d, arm_d} : KEY_NEUTRAL;
        locked_d = (state_d == S_LOCKOUT);
    end

    // FSM and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            code_q   <= 16'h0000;
            cnt_q    <= 3'd0;
            arm_q    <= 1'b0;
            fail_q   <= 2'd0;
            timer_q  <= 32'd0;
            key_q    <= KEY_NEUTRAL;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            arm_q    <= arm_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            key_q    <= key_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign KEY       = key_q;
    assign DIGIT_CNT = cnt_q;
    assign LOCKED    = locked_q;
    assign ERR       = err_q;

endmodule
